sam_mouse_protocol: RTL and testbench

//  Converts decoded PS/2 mouse packets into the SAM Coupe mouse nibble protocol.

---
 rtl/sam_mouse_protocol_pkg.sv | 28 ++
 rtl/sam_mouse_protocol_if.sv | 23 ++
 rtl/sam_mouse_acc.sv | 55 +++++
 rtl/sam_mouse_protocol.sv | 110 +++++++++++
 tb/tb_sam_mouse_protocol.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sam_mouse_protocol_pkg.sv
// Shared constants and types for the SAM Coupe mouse nibble protocol.
// The sequence index enum doubles as the state type of the nibble sequencer.
package sam_mouse_protocol_pkg;

    localparam int         SEQ_LEN    = 9;
    localparam int         DELTA_W    = 9;
    localparam int         BTN_W      = 3;
    localparam int         ACC_W_DEF  = 12;
    localparam int         ACC_MAX    = 2047;
    localparam int         ACC_MIN    = -2048;
    localparam logic [3:0] HDR_NIBBLE = 4'hF;

    typedef enum logic [3:0] {
        IDX_HDR = 4'd0,
        IDX_BTN = 4'd1,
        IDX_YH  = 4'd2,
        IDX_YM  = 4'd3,
        IDX_YL  = 4'd4,
        IDX_XH  = 4'd5,
        IDX_XM  = 4'd6,
        IDX_XL  = 4'd7,
        IDX_END = 4'd8
    } seq_idx_e;

    localparam int AXIS_X = 0;
    localparam int AXIS_Y = 1;

endpackage

// File: rtl/sam_mouse_protocol_if.sv
// Packet intake from the PS/2 decoder plus the CPU-facing read strobe and nibble.
// master = upstream/CPU side driving packets and rdmsel, slave = protocol block.
interface sam_mouse_protocol_if;

    logic                                       pkt_valid;
    logic [sam_mouse_protocol_pkg::DELTA_W-1:0] pkt_dx;
    logic [sam_mouse_protocol_pkg::DELTA_W-1:0] pkt_dy;
    logic [sam_mouse_protocol_pkg::BTN_W-1:0]   pkt_btn;
    logic                                       rdmsel;
    logic [3:0]                                 mdata;
    logic [3:0]                                 seq_idx;

    modport master (
        output pkt_valid, pkt_dx, pkt_dy, pkt_btn, rdmsel,
        input  mdata, seq_idx
    );

    modport slave (
        input  pkt_valid, pkt_dx, pkt_dy, pkt_btn, rdmsel,
        output mdata, seq_idx
    );

endinterface

// File: rtl/sam_mouse_acc.sv
// Signed saturating movement accumulator with snapshot register.
// Snapshot copies the running total and restarts it; an add in that cycle loads the delta.
module sam_mouse_acc #(
    parameter int ACC_W = 12,
    parameter int DW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_add,
    input  logic [DW-1:0]    i_delta,
    input  logic             i_snap,
    output logic [ACC_W-1:0] o_snap
);

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_snap;
    logic [ACC_W-1:0] w_delta_ext;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_next;

    assign w_delta_ext = {{(ACC_W-DW){i_delta[DW-1]}}, i_delta};
    assign w_sum       = {r_acc[ACC_W-1], r_acc} + {w_delta_ext[ACC_W-1], w_delta_ext};

    // One extra sum bit is enough: a single delta never exceeds one wrap of the range.
    always_comb begin
        w_acc_next = r_acc;
        if (i_snap) begin
            w_acc_next = i_add ? w_delta_ext : '0;
        end else if (i_add) begin
            if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
                w_acc_next = w_sum[ACC_W] ? SAT_MIN : SAT_MAX;
            end else begin
                w_acc_next = w_sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_snap <= '0;
        end else begin
            r_acc <= w_acc_next;
            if (i_snap) begin
                r_snap <= r_acc;
            end
        end
    end

    assign o_snap = r_snap;

endmodule

// File: rtl/sam_mouse_protocol.sv
// PS/2 packet to SAM Coupe mouse nibble sequencer: accumulates motion between polls
// and steps through a 9-nibble sequence on each falling edge of the port read strobe.
module sam_mouse_protocol
    import sam_mouse_protocol_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 600,
    parameter int ACC_W          = ACC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    sam_mouse_protocol_if.slave  bus
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             r_rd_d;
    seq_idx_e         r_seq_idx;
    seq_idx_e         w_idx_next;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_next;
    logic [3:0]       r_mdata;
    logic [3:0]       w_mdata_next;
    logic [BTN_W-1:0] r_btn;
    logic             w_fall;
    logic             w_tmo_hit;
    logic             w_snap_en;

    logic [DELTA_W-1:0] w_delta [2];
    logic [ACC_W-1:0]   w_snap  [2];

    assign w_delta[AXIS_X] = bus.pkt_dx;
    assign w_delta[AXIS_Y] = bus.pkt_dy;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            sam_mouse_acc #(
                .ACC_W (ACC_W),
                .DW    (DELTA_W)
            ) u_acc (
                .clk     (clk),
                .rst     (rst),
                .i_add   (bus.pkt_valid),
                .i_delta (w_delta[gi]),
                .i_snap  (w_snap_en),
                .o_snap  (w_snap[gi])
            );
        end
    endgenerate

    assign w_fall    = r_rd_d & ~bus.rdmsel;
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES)) && !bus.rdmsel;
    assign w_snap_en = w_fall && (r_seq_idx == IDX_HDR);

    always_comb begin
        w_idx_next = r_seq_idx;
        w_tmo_next = r_tmo;

        if (w_fall) begin
            w_idx_next = (r_seq_idx == IDX_END) ? IDX_HDR : seq_idx_e'(r_seq_idx + 4'd1);
        end else if (w_tmo_hit) begin
            w_idx_next = IDX_HDR;
        end

        // Counter only runs in the gaps between reads of an unfinished sequence.
        if (w_fall || bus.rdmsel || (r_seq_idx == IDX_HDR)) begin
            w_tmo_next = '0;
        end else if (r_tmo != TMO_W'(TIMEOUT_CYCLES)) begin
            w_tmo_next = r_tmo + 1'b1;
        end
    end

    // Output register is fed from the next index so the new nibble appears with the index.
    always_comb begin
        w_mdata_next = HDR_NIBBLE;
        case (w_idx_next)
            IDX_HDR: w_mdata_next = HDR_NIBBLE;
            IDX_BTN: w_mdata_next = {1'b1, ~r_btn};
            IDX_YH:  w_mdata_next = w_snap[AXIS_Y][ACC_W-1 -: 4];
            IDX_YM:  w_mdata_next = w_snap[AXIS_Y][7:4];
            IDX_YL:  w_mdata_next = w_snap[AXIS_Y][3:0];
            IDX_XH:  w_mdata_next = w_snap[AXIS_X][ACC_W-1 -: 4];
            IDX_XM:  w_mdata_next = w_snap[AXIS_X][7:4];
            IDX_XL:  w_mdata_next = w_snap[AXIS_X][3:0];
            IDX_END: w_mdata_next = HDR_NIBBLE;
            default: w_mdata_next = HDR_NIBBLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_d    <= 1'b0;
            r_seq_idx <= IDX_HDR;
            r_tmo     <= '0;
            r_mdata   <= HDR_NIBBLE;
            r_btn     <= '0;
        end else begin
            r_rd_d    <= bus.rdmsel;
            r_seq_idx <= w_idx_next;
            r_tmo     <= w_tmo_next;
            r_mdata   <= w_mdata_next;
            if (bus.pkt_valid) begin
                r_btn <= bus.pkt_btn;
            end
        end
    end

    assign bus.mdata   = r_mdata;
    assign bus.seq_idx = r_seq_idx;

endmodule

// File: tb/tb_sam_mouse_protocol.sv
// Directed bench for the SAM mouse nibble sequencer: reset, sequence contents,
// saturation, timeout, read-held-high, packet/snapshot collision and mid-sequence reset.
module tb_sam_mouse_protocol;

    localparam int TMO = 600;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    sam_mouse_protocol_if bus ();

    sam_mouse_protocol #(
        .TIMEOUT_CYCLES (TMO),
        .ACC_W          (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(output logic [3:0] nib);
        bus.rdmsel = 1'b1;
        step(3);
        nib = bus.mdata;
        bus.rdmsel = 1'b0;
        step(2);
    endtask

    task automatic send_pkt(input logic [8:0] dx, input logic [8:0] dy, input logic [2:0] btn);
        bus.pkt_valid = 1'b1;
        bus.pkt_dx    = dx;
        bus.pkt_dy    = dy;
        bus.pkt_btn   = btn;
        step(1);
        bus.pkt_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(3);
        total++;
        if (bus.seq_idx !== 4'd0) begin bad++; $display("FAIL reset_idx got=%h exp=0", bus.seq_idx); end
        total++;
        if (bus.mdata !== 4'hF) begin bad++; $display("FAIL reset_mdata got=%h exp=F", bus.mdata); end
        rst = 1'b0;
        step(1);
        total++;
        if (bus.mdata !== 4'hF || bus.seq_idx !== 4'd0) begin
            bad++; $display("FAIL post_reset got=%h/%h exp=F/0", bus.mdata, bus.seq_idx);
        end
        $display("reset: mdata=%h idx=%0d", bus.mdata, bus.seq_idx);
    endtask

    task automatic test_idle_sequence;
        logic [3:0] exp [9];
        logic [3:0] nib;
        exp = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
        for (int i = 0; i < 9; i++) begin
            pulse(nib);
            total++;
            if (nib !== exp[i]) begin bad++; $display("FAIL idle_nib%0d got=%h exp=%h", i, nib, exp[i]); end
            $display("idle read %0d: mdata=%h", i, nib);
        end
        total++;
        if (bus.seq_idx !== 4'd0) begin bad++; $display("FAIL idle_wrap got=%h exp=0", bus.seq_idx); end
    endtask

    task automatic test_packet;
        logic [3:0] exp [9];
        logic [3:0] nib;
        exp = '{4'hF, 4'hE, 4'hF, 4'hF, 4'hD, 4'h0, 4'h0, 4'h5, 4'hF};
        send_pkt(9'd5, 9'h1FD, 3'b001);
        step(1);
        for (int i = 0; i < 9; i++) begin
            pulse(nib);
            total++;
            if (nib !== exp[i]) begin bad++; $display("FAIL pkt_nib%0d got=%h exp=%h", i, nib, exp[i]); end
            $display("packet read %0d: mdata=%h", i, nib);
        end
    endtask

    task automatic test_saturation;
        logic [3:0] exp_sat [9];
        logic [3:0] exp_clr [9];
        logic [3:0] exp_neg [9];
        logic [3:0] nib;
        exp_sat = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h7, 4'hF, 4'hF, 4'hF};
        exp_clr = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
        exp_neg = '{4'hF, 4'hF, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
        for (int k = 0; k < 300; k++) send_pkt(9'd100, 9'd0, 3'b000);
        step(1);
        for (int i = 0; i < 9; i++) begin
            pulse(nib);
            total++;
            if (nib !== exp_sat[i]) begin bad++; $display("FAIL sat_nib%0d got=%h exp=%h", i, nib, exp_sat[i]); end
            $display("saturated read %0d: mdata=%h", i, nib);
        end
        for (int i = 0; i < 9; i++) begin
            pulse(nib);
            total++;
            if (nib !== exp_clr[i]) begin bad++; $display("FAIL clr_nib%0d got=%h exp=%h", i, nib, exp_clr[i]); end
            $display("cleared read %0d: mdata=%h", i, nib);
        end
        for (int k = 0; k < 30; k++) send_pkt(9'd0, 9'h19C, 3'b000);
        step(1);
        for (int i = 0; i < 9; i++) begin
            pulse(nib);
            total++;
            if (nib !== exp_neg[i]) begin bad++; $display("FAIL neg_nib%0d got=%h exp=%h", i, nib, exp_neg[i]); end
            $display("neg-saturated read %0d: mdata=%h", i, nib);
        end
    endtask

    task automatic test_timeout;
        logic [3:0] exp [4];
        logic [3:0] nib;
        exp = '{4'hF, 4'hF, 4'h0, 4'h0};
        for (int i = 0; i < 4; i++) begin
            pulse(nib);
            total++;
            if (nib !== exp[i]) begin bad++; $display("FAIL tmo_nib%0d got=%h exp=%h", i, nib, exp[i]); end
        end
        step(TMO - 1);
        total++;
        if (bus.seq_idx !== 4'd4) begin bad++; $display("FAIL tmo_early got=%h exp=4", bus.seq_idx); end
        $display("timeout: idx after %0d idle = %0d", TMO - 1, bus.seq_idx);
        step(3);
        total++;
        if (bus.seq_idx !== 4'd0) begin bad++; $display("FAIL tmo_idx got=%h exp=0", bus.seq_idx); end
        total++;
        if (bus.mdata !== 4'hF) begin bad++; $display("FAIL tmo_mdata got=%h exp=F", bus.mdata); end
        $display("timeout: idx after %0d idle = %0d mdata=%h", TMO + 2, bus.seq_idx, bus.mdata);
    endtask

    task automatic test_hold_high;
        logic [3:0] nib;
        pulse(nib);
        pulse(nib);
        bus.rdmsel = 1'b1;
        step(TMO + 100);
        total++;
        if (bus.seq_idx !== 4'd2) begin bad++; $display("FAIL hold_idx got=%h exp=2", bus.seq_idx); end
        bus.rdmsel = 1'b0;
        step(2);
        total++;
        if (bus.seq_idx !== 4'd3) begin bad++; $display("FAIL hold_release got=%h exp=3", bus.seq_idx); end
        step(TMO + 10);
        total++;
        if (bus.seq_idx !== 4'd0) begin bad++; $display("FAIL hold_tmo got=%h exp=0", bus.seq_idx); end
        $display("hold high: idx after release+timeout = %0d", bus.seq_idx);
    endtask

    task automatic test_simultaneous;
        logic [3:0] exp1 [9];
        logic [3:0] exp2 [9];
        logic [3:0] nib;
        exp1 = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'hF};
        exp2 = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'hF};
        send_pkt(9'd2, 9'd0, 3'b000);
        bus.rdmsel = 1'b1;
        step(3);
        nib = bus.mdata;
        total++;
        if (nib !== exp1[0]) begin bad++; $display("FAIL coll_nib0 got=%h exp=F", nib); end
        bus.rdmsel    = 1'b0;
        bus.pkt_valid = 1'b1;
        bus.pkt_dx    = 9'd7;
        bus.pkt_dy    = 9'd0;
        bus.pkt_btn   = 3'b000;
        step(1);
        bus.pkt_valid = 1'b0;
        step(1);
        total++;
        if (bus.seq_idx !== 4'd1) begin bad++; $display("FAIL coll_idx got=%h exp=1", bus.seq_idx); end
        for (int i = 1; i < 9; i++) begin
            pulse(nib);
            total++;
            if (nib !== exp1[i]) begin bad++; $display("FAIL coll1_nib%0d got=%h exp=%h", i, nib, exp1[i]); end
            $display("collision snapshot read %0d: mdata=%h", i, nib);
        end
        for (int i = 0; i < 9; i++) begin
            pulse(nib);
            total++;
            if (nib !== exp2[i]) begin bad++; $display("FAIL coll2_nib%0d got=%h exp=%h", i, nib, exp2[i]); end
            $display("follow-up read %0d: mdata=%h", i, nib);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] nib;
        for (int i = 0; i < 5; i++) pulse(nib);
        total++;
        if (bus.seq_idx !== 4'd5) begin bad++; $display("FAIL mid_pre got=%h exp=5", bus.seq_idx); end
        bus.rdmsel = 1'b1;
        step(1);
        rst = 1'b1;
        step(1);
        total++;
        if (bus.seq_idx !== 4'd0) begin bad++; $display("FAIL mid_rst_idx got=%h exp=0", bus.seq_idx); end
        total++;
        if (bus.mdata !== 4'hF) begin bad++; $display("FAIL mid_rst_mdata got=%h exp=F", bus.mdata); end
        rst        = 1'b0;
        bus.rdmsel = 1'b0;
        step(3);
        total++;
        if (bus.seq_idx !== 4'd0) begin bad++; $display("FAIL mid_no_adv got=%h exp=0", bus.seq_idx); end
        $display("mid-sequence reset: idx=%0d mdata=%h", bus.seq_idx, bus.mdata);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.pkt_dx    = '0;
        bus.pkt_dy    = '0;
        bus.pkt_btn   = '0;
        bus.rdmsel    = 1'b0;
        test_reset();
        test_idle_sequence();
        test_packet();
        test_saturation();
        test_timeout();
        test_hold_high();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
